// File: rtl/ternary_mm_sequencer.sv
// ternary_mm_sequencer: streams host beats into the 4-row ternary MAC array
// and collects its serialized readout. Define RELU_EN to zero negative result bytes.
module ternary_mm_sequencer #(
  parameter int ROWS           = 4,
  parameter bit FLUSH_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_weights,
  input  logic [7:0]        in_act,
  input  logic              in_last,
  output logic [7:0]        mm_weights,
  output logic [7:0]        mm_act,
  output logic              mm_ena,
  input  logic [7:0]        mm_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*ROWS-1:0] out_data,
  output logic              busy
);

  typedef enum logic {S_FLUSH, S_RUN} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(ROWS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_mm_w;
  logic [7:0]        r_mm_a;
  logic              r_ena;
  logic [2:0]        r_cnt;
  logic              r_discard;
  logic [7:0]        r_shadow [ROWS];
  logic              r_out_valid;
  logic [8*ROWS-1:0] r_out_data;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_ena;
  logic              w_capture;
  logic              w_final;
  logic [1:0]        w_idx;

  function automatic logic [7:0] f_relu(input logic [7:0] b);
`ifdef RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction

  // Next state and beat acceptance
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    unique case (r_state)
      S_FLUSH: w_state_nxt = S_RUN;
      S_RUN: w_in_ready = !in_last ||
        (r_cnt == 3'd0 && (!r_out_valid || out_ready));
    endcase
  end

  assign w_accept  = in_valid && w_in_ready;
  // The flush strobe is the single FLUSH cycle itself
  assign w_ena     = r_ena && (r_state != S_FLUSH);
  // No capture on the strobe cycle; bytes start the cycle after
  assign w_capture = (r_cnt != 3'd0) && w_ena;
  assign w_final   = w_capture && (r_cnt == 3'd1) && !r_discard;
  assign w_idx     = 2'(CNT_LOAD - r_cnt);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= FLUSH_ON_RESET ? S_FLUSH : S_RUN;
    else       r_state <= w_state_nxt;
  end

  // Array pin drive: accepted beat or an idle zero-weight cycle
  always_ff @(posedge clk) begin
    if (reset || !w_accept) begin
      r_mm_w <= 8'h00;
      r_mm_a <= 8'h00;
      r_ena  <= 1'b1;
    end else begin
      r_mm_w <= in_weights;
      r_mm_a <= in_act;
      r_ena  <= !in_last;
    end
  end

  // Collect counter, discard flag and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= 3'd0;
      r_discard   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (r_state == S_FLUSH) begin
        r_cnt     <= CNT_LOAD;
        r_discard <= 1'b1;
      end else if (w_accept && in_last) begin
        r_cnt     <= CNT_LOAD;
        r_discard <= 1'b0;
      end else if (w_capture) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_final) begin
        for (int r = 0; r < ROWS-1; r++)
          r_out_data[8*r +: 8] <= f_relu(r_shadow[r]);
        r_out_data[8*(ROWS-1) +: 8] <= f_relu(mm_out);
        r_out_valid <= 1'b1;
      end
    end
  end

  // Shadow capture of serialized readout bytes
  always_ff @(posedge clk) begin
    if (w_capture) r_shadow[w_idx] <= mm_out;
  end

  assign in_ready   = w_in_ready;
  assign mm_weights = r_mm_w;
  assign mm_act     = r_mm_a;
  assign mm_ena     = w_ena;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = (r_state == S_FLUSH) || (r_cnt != 3'd0);

endmodule

// File: tb/tb_ternary_mm_sequencer.sv
// tb_ternary_mm_sequencer: directed bench with a behavioural
// model of the 4-row ternary MAC array on the mm_* pins.
module tb_ternary_mm_sequencer;

`ifdef RELU_EN
  localparam logic [31:0] EXP_A = 32'h0100_0001;
  localparam logic [31:0] EXP_C = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_A = 32'h0100_FE01;
  localparam logic [31:0] EXP_C = 32'hFF00_00FF;
`endif
  localparam logic [31:0] EXP_B = 32'h0202_0202;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_weights = 8'h00;
  logic [7:0]  in_act = 8'h00;
  logic        in_last = 1'b0;
  logic [7:0]  mm_weights;
  logic [7:0]  mm_act;
  logic        mm_ena;
  logic [7:0]  mm_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  ternary_mm_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_weights(in_weights), .in_act(in_act), .in_last(in_last),
    .mm_weights(mm_weights), .mm_act(mm_act), .mm_ena(mm_ena),
    .mm_out(mm_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Array model: accumulate while enabled; on the strobe include the
  // beat, snapshot bits [15:8] per row, clear, then shift bytes out.
  int          acc [4];
  logic [7:0]  q [4];
  int          qidx = 4;

  function automatic int contrib(input logic [7:0] w, input logic [7:0] a,
                                 input int r);
    logic [1:0] wc;
    wc = w[7-2*r -: 2];
    if (wc == 2'b00) return 0;
    if (wc == 2'b01) return int'($signed(a));
    return -int'($signed(a));
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (mm_ena) begin
        acc[r] <= acc[r] + contrib(mm_weights, mm_act, r);
      end else begin
        q[r]   <= 8'((acc[r] + contrib(mm_weights, mm_act, r)) >>> 8);
        acc[r] <= 0;
      end
    end
    if (!mm_ena)      qidx <= 0;
    else if (qidx < 4) qidx <= qidx + 1;
  end

  assign mm_out = (qidx < 4) ? q[qidx[1:0]] : 8'h00;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, wait (bounded) for acceptance, return in the
  // cycle the beat is on the array pins
  task automatic send(input logic [7:0] w, input logic [7:0] a,
                      input logic last);
    int n;
    in_valid = 1'b1; in_weights = w; in_act = a; in_last = last;
    #1;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0; in_weights = 8'h00; in_act = 8'h00;
  endtask

  // From the strobe cycle, count cycles until out_valid (bounded)
  task automatic wait_result(input string tag, input logic [31:0] exp);
    int k;
    k = 0;
    while (!out_valid && k < 12) begin
      step();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd5);
    check({tag, "_data"}, out_data, exp);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values and flush
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_mm_weights", 32'(mm_weights), 32'd0);
    check("rst_mm_act", 32'(mm_act), 32'd0);
    reset = 1'b0;
    check("flush_ena", 32'(mm_ena), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd0);
    check("flush_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("flush_busy_seq", 32'(busy), (i < 5) ? 32'd1 : 32'd0);
      check("flush_no_valid", 32'(out_valid), 32'd0);
    end
    check("idle_ena", 32'(mm_ena), 32'd1);

    // Mixed-sign rows, act=100
    for (int b = 0; b < 3; b++) send(8'b0111_0001, 8'd100, 1'b0);
    check("a_ena_b3", 32'(mm_ena), 32'd1);
    send(8'b0111_0001, 8'd100, 1'b1);
    check("a_strobe", 32'(mm_ena), 32'd0);
    check("a_strobe_w", 32'(mm_weights), 32'h71);
    wait_result("a", EXP_A);
    drain("a");

    // -128 times -1 on every row, four beats
    for (int b = 0; b < 3; b++) send(8'hFF, 8'h80, 1'b0);
    send(8'hFF, 8'h80, 1'b1);
    wait_result("b", EXP_B);
    drain("b");

    // Early last beat stalls on the counter, then on the pending result
    for (int b = 0; b < 3; b++) send(8'b0111_0001, 8'd100, 1'b0);
    send(8'b0111_0001, 8'd100, 1'b1);
    step();
    step();
    in_valid = 1'b1; in_last = 1'b1;
    in_weights = 8'b0111_0001; in_act = 8'h80;
    #1;
    for (int i = 2; i <= 6; i++) begin
      check("c_stall_ready", 32'(in_ready), 32'd0);
      if (i >= 5) begin
        check("c_first_valid", 32'(out_valid), 32'd1);
        check("c_first_data", out_data, EXP_A);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    check("c_ready_on_drain", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0;
    check("c_second_strobe", 32'(mm_ena), 32'd0);
    check("c_first_consumed", 32'(out_valid), 32'd0);
    wait_result("c", EXP_C);
    drain("c");

    // Reset while two bytes remain to collect
    for (int b = 0; b < 3; b++) send(8'b0111_0001, 8'd100, 1'b0);
    send(8'b0111_0001, 8'd100, 1'b1);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("d_flush_ena", 32'(mm_ena), 32'd0);
    check("d_flush_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("d_no_valid", 32'(out_valid), 32'd0);
    end
    check("d_idle", 32'(busy), 32'd0);
    for (int b = 0; b < 3; b++) send(8'hFF, 8'h80, 1'b0);
    send(8'hFF, 8'h80, 1'b1);
    wait_result("d", EXP_B);
    drain("d");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
